// File: rtl/load_enable_register.sv
// load_enable_register: parallel-load holding register with clock enable.
// Captures `in` on a rising edge of `clk` when both `en` and `load` are high,
// otherwise holds. Asynchronous active-low reset to RESET_VALUE.
// Optional feature macro: LOAD_ENABLE_REGISTER_PARITY_EN adds a registered
// even-parity output `parity_out` that tracks `out`.
module load_enable_register #(
  parameter int          WIDTH       = 4,
  parameter logic [63:0] RESET_VALUE = 64'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             en,
`ifdef LOAD_ENABLE_REGISTER_PARITY_EN
  output logic             parity_out,
`endif
  output logic [WIDTH-1:0] out
);

  // Reset value truncated to the register width.
  localparam logic [WIDTH-1:0] RST_V = RESET_VALUE[WIDTH-1:0];

  // A capture happens only when the enable qualifies the load request.
  logic capture;
  assign capture = en & load;

  // Storage register: async clear wins, otherwise load when qualified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= RST_V;
    end else if (capture) begin
      out <= in;
    end
  end

`ifdef LOAD_ENABLE_REGISTER_PARITY_EN
  localparam logic RST_PAR = ^RST_V;

  // Parity flop updated on the same edge as `out` so the pair never disagrees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_out <= RST_PAR;
    end else if (capture) begin
      parity_out <= ^in;
    end
  end
`endif

`ifndef SYNTHESIS
  // Simulation-only check that the controls are driven while out of reset.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown({load, en}))
        else $error("load_enable_register: X/Z on load or en");
    end
  end
`endif

endmodule

// File: tb/tb_load_enable_register.sv
// Directed testbench for load_enable_register (WIDTH=4, 20 ns clock).
module tb_load_enable_register;

  logic       clk;
  logic       rst_n;
  logic [3:0] in;
  logic       load;
  logic       en;
  logic [3:0] out;
`ifdef LOAD_ENABLE_REGISTER_PARITY_EN
  logic       parity_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  load_enable_register #(.WIDTH(4), .RESET_VALUE(64'd0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in),
    .load       (load),
    .en         (en),
`ifdef LOAD_ENABLE_REGISTER_PARITY_EN
    .parity_out (parity_out),
`endif
    .out        (out)
  );

  // Rising edges at 10, 30, 50 ns ...
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic at(input time t);
    if (t > $time) #(t - $time);
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
      end
  endtask

  initial begin
    // Step 1: reset held with load qualified
    rst_n = 1'b0; en = 1'b1; load = 1'b1; in = 4'b0000;
    at(5);   check("reset_pre_edge", out, 4'b0000);
    in = 4'b1010;
    at(11);  check("reset_over_edge", out, 4'b0000);
    at(20);  rst_n = 1'b1; load = 1'b0; in = 4'b1111;

    // Step 2: load low, in changing, must hold
    at(31);  check("hold_load0_e30", out, 4'b0000);
    at(40);  in = 4'b0101;
    at(51);  check("hold_load0_e50", out, 4'b0000);
    at(60);  in = 4'b1111;
    at(71);  check("hold_load0_e70", out, 4'b0000);
    at(91);  check("hold_load0_e90", out, 4'b0000);

    // Step 3: capture 1001, remains while in unchanged
    at(100); in = 4'b1001; load = 1'b1;
    at(109); check("no_capture_before_edge", out, 4'b0000);
    at(111); check("capture_1001", out, 4'b1001);
    at(131); check("recapture_1001", out, 4'b1001);

    // Step 4: capture 0110, then en=0 blocks load for three edges
    at(140); in = 4'b0110;
    at(151); check("capture_0110", out, 4'b0110);
    at(160); en = 1'b0; load = 1'b1; in = 4'b1111;
    at(171); check("en0_hold_e170", out, 4'b0110);
    at(191); check("en0_hold_e190", out, 4'b0110);
    at(211); check("en0_hold_e210", out, 4'b0110);
    at(220); en = 1'b1;
    at(231); check("en1_capture_1111", out, 4'b1111);

    // Step 5: async reset mid-cycle while loading
    at(240); in = 4'b1001;
    at(251); check("capture_1001_b", out, 4'b1001);
    at(260); rst_n = 1'b0;
    at(261); check("async_clear", out, 4'b0000);
    at(271); check("clear_wins_edge", out, 4'b0000);
    at(280); rst_n = 1'b1; load = 1'b0; in = 4'b1110;
    at(291); check("post_release_hold", out, 4'b0000);
    at(300); load = 1'b1; in = 4'b0101;
    at(311); check("post_release_load", out, 4'b0101);

    // load held high: out tracks in one cycle later
    at(320); in = 4'b1010;
    at(329); check("track_before_edge", out, 4'b0101);
    at(331); check("track_1010", out, 4'b1010);
    at(340); in = 4'b0011;
    at(351); check("track_0011", out, 4'b0011);

`ifdef LOAD_ENABLE_REGISTER_PARITY_EN
    // Step 6: parity tracks out on the same edge
    at(360); in = 4'b1001;
    at(371); check("par_out_1001", out, 4'b1001);
             check("parity_1001", {3'b000, parity_out}, 4'b0000);
    at(380); in = 4'b0111;
    at(391); check("par_out_0111", out, 4'b0111);
             check("parity_0111", {3'b000, parity_out}, 4'b0001);
    at(400); in = 4'b0000;
    at(411); check("par_out_0000", out, 4'b0000);
             check("parity_0000", {3'b000, parity_out}, 4'b0000);
    at(420); in = 4'b0001; en = 1'b0;
    at(431); check("parity_en0_hold", {3'b000, parity_out}, 4'b0000);
    at(440); en = 1'b1;
    at(451); check("parity_0001", {3'b000, parity_out}, 4'b0001);
    at(460); rst_n = 1'b0;
    at(461); check("parity_async_clear", {3'b000, parity_out}, 4'b0000);
    rst_n = 1'b1;
`endif

    at(480);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
